// File: rtl/ff_pkt_arbiter_if.sv
// Bundle of the per-port request streams, the filter drive, and the result tag/status signals.
// The arbiter connects to the slave modport; the traffic source / filter side uses master.
interface ff_pkt_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned EWIDTH    = 4
);
  localparam int unsigned TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*DWIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0]        s_valid;
  logic [NUM_PORTS-1:0]        s_sop;
  logic [NUM_PORTS-1:0]        s_eop;
  logic [NUM_PORTS*EWIDTH-1:0] s_empty;
  logic [NUM_PORTS-1:0]        s_ready;

  logic [DWIDTH-1:0]           ff_data;
  logic                        ff_valid;
  logic                        ff_sop;
  logic                        ff_eop;
  logic [EWIDTH-1:0]           ff_empty;
  logic                        ff_out_valid;

  logic [TAG_W-1:0]            m_tag;
  logic                        m_tag_valid;
  logic                        m_tag_eop;
  logic                        err_sop;
  logic                        err_align;

  modport master (
    output s_data, s_valid, s_sop, s_eop, s_empty, ff_out_valid,
    input  s_ready, ff_data, ff_valid, ff_sop, ff_eop, ff_empty,
    input  m_tag, m_tag_valid, m_tag_eop, err_sop, err_align
  );

  modport slave (
    input  s_data, s_valid, s_sop, s_eop, s_empty, ff_out_valid,
    output s_ready, ff_data, ff_valid, ff_sop, ff_eop, ff_empty,
    output m_tag, m_tag_valid, m_tag_eop, err_sop, err_align
  );
endinterface

// File: rtl/ff_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one shared first-filter, with a port tag
// pipeline aligned to the filter's fixed latency so results can be demultiplexed.
module ff_pkt_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DWIDTH     = 128,
  parameter int unsigned EWIDTH     = 4,
  parameter int unsigned FF_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  ff_pkt_arbiter_if.slave    bus_io
);
  localparam int unsigned TAG_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q;
  logic [TAG_W-1:0]       grant_q;
  logic [TAG_W-1:0]       ptr_q;
  logic [NUM_PORTS-1:0]   ready_q;
  logic                   first_q;
  logic [DWIDTH-1:0]      ff_data_q;
  logic [EWIDTH-1:0]      ff_empty_q;
  logic                   ff_valid_q;
  logic                   ff_sop_q;
  logic                   ff_eop_q;
  logic                   err_sop_q;
  logic                   err_align_q;
  logic                   tv_q [FF_LATENCY];
  logic                   te_q [FF_LATENCY];
  logic [TAG_W-1:0]       tt_q [FF_LATENCY];

  logic [DWIDTH-1:0]      data_arr_c  [NUM_PORTS];
  logic [EWIDTH-1:0]      empty_arr_c [NUM_PORTS];
  logic [TAG_W-1:0]       pick_c;
  logic                   pick_vld_c;
  logic [TAG_W-1:0]       idx_c;
  logic                   xfer_c;

  // Unpack the flat per-port buses.
  always_comb begin
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      data_arr_c[i]  = bus_io.s_data[i*DWIDTH +: DWIDTH];
      empty_arr_c[i] = bus_io.s_empty[i*EWIDTH +: EWIDTH];
    end
  end

  // Round-robin scan starting just above the last finished port.
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    idx_c      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx_c = TAG_W'((32'(ptr_q) + k) % NUM_PORTS);
      if (!pick_vld_c && bus_io.s_valid[idx_c]) begin
        pick_c     = idx_c;
        pick_vld_c = 1'b1;
      end
    end
  end

  assign xfer_c = ready_q[grant_q] & bus_io.s_valid[grant_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= TAG_W'(NUM_PORTS - 1);
      ready_q     <= '0;
      first_q     <= 1'b0;
      ff_data_q   <= '0;
      ff_empty_q  <= '0;
      ff_valid_q  <= 1'b0;
      ff_sop_q    <= 1'b0;
      ff_eop_q    <= 1'b0;
      err_sop_q   <= 1'b0;
      err_align_q <= 1'b0;
      for (int unsigned i = 0; i < FF_LATENCY; i++) begin
        tv_q[i] <= 1'b0;
        te_q[i] <= 1'b0;
        tt_q[i] <= '0;
      end
    end else begin
      ff_valid_q <= xfer_c;
      if (xfer_c) begin
        ff_data_q  <= data_arr_c[grant_q];
        ff_empty_q <= empty_arr_c[grant_q];
        ff_sop_q   <= bus_io.s_sop[grant_q];
        ff_eop_q   <= bus_io.s_eop[grant_q];
      end else begin
        ff_eop_q   <= 1'b0;
      end

      // Tag pipeline mirrors the filter's fixed latency.
      tv_q[0] <= ff_valid_q;
      te_q[0] <= ff_eop_q;
      tt_q[0] <= grant_q;
      for (int unsigned i = 1; i < FF_LATENCY; i++) begin
        tv_q[i] <= tv_q[i-1];
        te_q[i] <= te_q[i-1];
        tt_q[i] <= tt_q[i-1];
      end

      err_align_q <= err_align_q | (bus_io.ff_out_valid != tv_q[FF_LATENCY-1]);

      case (state_q)
        IDLE: begin
          if (pick_vld_c) begin
            grant_q <= pick_c;
            ready_q <= NUM_PORTS'(1) << pick_c;
            first_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (xfer_c) begin
            first_q <= 1'b0;
            if (first_q && !bus_io.s_sop[grant_q]) err_sop_q <= 1'b1;
            if (bus_io.s_eop[grant_q]) begin
              ptr_q   <= grant_q;
              ready_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.s_ready     = ready_q;
  assign bus_io.ff_data     = ff_data_q;
  assign bus_io.ff_valid    = ff_valid_q;
  assign bus_io.ff_sop      = ff_sop_q;
  assign bus_io.ff_eop      = ff_eop_q;
  assign bus_io.ff_empty    = ff_empty_q;
  assign bus_io.m_tag       = tt_q[FF_LATENCY-1];
  assign bus_io.m_tag_valid = tv_q[FF_LATENCY-1];
  assign bus_io.m_tag_eop   = te_q[FF_LATENCY-1];
  assign bus_io.err_sop     = err_sop_q;
  assign bus_io.err_align   = err_align_q;
endmodule

// File: tb/tb_ff_pkt_arbiter.sv
// Scoreboard bench for ff_pkt_arbiter: packet-level traffic model plus round-robin,
// forwarding, tag-latency and sticky-error expectations derived from the arbiter's rules.
`timescale 1ns/1ps
module tb_ff_pkt_arbiter;
  localparam int NP = 4, DW = 128, EW = 4, TW = 2, LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ff_pkt_arbiter_if #(.NUM_PORTS(NP), .DWIDTH(DW), .EWIDTH(EW)) bus ();
  ff_pkt_arbiter #(.NUM_PORTS(NP), .DWIDTH(DW), .EWIDTH(EW), .FF_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus)
  );

  typedef struct {int len; bit bad_sop; int gap_at; int gap_len; logic [EW-1:0] empty;} pkt_t;
  typedef struct {logic [DW-1:0] data; bit sop; bit eop; logic [EW-1:0] empty; int cyc;} ffx_t;
  typedef struct {int port; bit eop; int cyc;} tagx_t;

  pkt_t  pq [NP][$];
  ffx_t  ffq[$];
  tagx_t tagq[$];
  int    grant_log[$];

  int n_checks = 0, n_errors = 0, cyc = 0;
  bit act [NP];
  int len [NP], beat [NP], gap_at [NP], gap_left [NP];
  bit bad [NP];
  logic [EW-1:0] emp [NP];
  logic [DW-1:0] dat [NP];
  logic [NP-1:0] xfer_pend = '0, prev_valid = '0, prev_ready = '0;
  bit prev_rst = 1'b0, prev_eop_x = 1'b0;
  int ptr_m = NP - 1, owner = -1, flt_lat = LAT;
  bit err_sop_exp = 1'b0, align_chk = 1'b1;
  bit hist [8];

  task automatic chk(input string name, input logic [255:0] act_v, input logic [255:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic pkt_t mk(int l, bit b, int ga, int gl, logic [EW-1:0] e);
    pkt_t p;
    p.len = l; p.bad_sop = b; p.gap_at = ga; p.gap_len = gl; p.empty = e;
    return p;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First requesting port above p, wrapping; -1 if none.
  function automatic int rr(input int p, input logic [NP-1:0] v);
    for (int k = 1; k <= NP; k++) begin
      int q;
      q = (p + k) % NP;
      if (v[q]) return q;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = (ffq.size() != 0) || (tagq.size() != 0);
    for (int i = 0; i < NP; i++) b |= act[i] || (pq[i].size() != 0);
    return b;
  endfunction

  // One negedge step: observe the last edge, advance traffic, drive inputs, model the filter.
  task automatic drive_cycle();
    logic [NP-1:0]    rdy, vld, sop, eop, ex;
    logic [NP*DW-1:0] dv;
    logic [NP*EW-1:0] ev;
    int e;
    rdy = bus.s_ready;
    if (prev_rst && prev_ready == '0 && (rdy != '0 || prev_valid != '0)) begin
      e  = rr(ptr_m, prev_valid);
      ex = '0;
      if (e >= 0) ex[e] = 1'b1;
      chk("grant", rdy, ex);
      if (rdy != '0) grant_log.push_back(e);
    end
    if (prev_rst && prev_eop_x) chk("ready_drop_after_eop", rdy, 0);

    for (int i = 0; i < NP; i++) begin
      if (xfer_pend[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) act[i] = 1'b0;
        else dat[i] = rnd_data();
      end
      if (!act[i] && pq[i].size() != 0) begin
        pkt_t p;
        p = pq[i].pop_front();
        act[i] = 1'b1; len[i] = p.len; beat[i] = 0; bad[i] = p.bad_sop;
        gap_at[i] = p.gap_at; gap_left[i] = p.gap_len; emp[i] = p.empty;
        dat[i] = rnd_data();
      end
    end

    vld = '0; sop = '0; eop = '0; dv = bus.s_data; ev = '0;
    for (int i = 0; i < NP; i++) begin
      if (act[i]) begin
        if (beat[i] == gap_at[i] && gap_left[i] > 0) gap_left[i]--;
        else vld[i] = 1'b1;
        sop[i] = (beat[i] == 0) && !bad[i];
        eop[i] = (beat[i] == len[i] - 1);
        dv[i*DW +: DW] = dat[i];
        if (eop[i]) ev[i*EW +: EW] = emp[i];
      end
    end
    bus.s_valid = vld; bus.s_sop = sop; bus.s_eop = eop; bus.s_data = dv; bus.s_empty = ev;

    xfer_pend  = vld & rdy & {NP{rst_n}};
    prev_eop_x = 1'b0;
    for (int i = 0; i < NP; i++) begin
      if (xfer_pend[i]) begin
        ffx_t  f;
        tagx_t t;
        if (beat[i] == 0) begin
          chk("pkt_start_while_other_open", owner, -1);
          owner = i;
          if (bad[i]) err_sop_exp = 1'b1;
        end else begin
          chk("pkt_owner", i, owner);
        end
        if (eop[i]) begin
          owner = -1; ptr_m = i; prev_eop_x = 1'b1;
        end
        f.data = dat[i]; f.sop = sop[i]; f.eop = eop[i]; f.empty = ev[i*EW +: EW]; f.cyc = cyc + 1;
        t.port = i; t.eop = eop[i]; t.cyc = cyc + 1 + LAT;
        ffq.push_back(f);
        tagq.push_back(t);
      end
    end
    prev_valid = vld; prev_ready = rdy; prev_rst = rst_n;

    // Filter model: out_valid is in_valid delayed by flt_lat cycles.
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus.ff_valid;
    if (!rst_n) for (int k = 0; k < 8; k++) hist[k] = 1'b0;
    bus.ff_out_valid = hist[flt_lat];
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_cycle();
    end
  endtask

  task automatic run_done(input int max_cyc, input string name);
    int c;
    c = 0;
    while (busy() && c < max_cyc) begin
      @(negedge clk);
      drive_cycle();
      c++;
    end
    if (busy()) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_n = 1'b0;
      ffq.delete(); tagq.delete();
      err_sop_exp = 1'b0; ptr_m = NP - 1; owner = -1; xfer_pend = '0;
      for (int i = 0; i < NP; i++) begin
        act[i] = 1'b0;
        pq[i].delete();
      end
      drive_cycle();
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle();
  endtask

  // Monitor: samples just after each rising edge and pops the scoreboards.
  initial begin
    logic  r;
    ffx_t  fe;
    tagx_t te;
    forever begin
      @(posedge clk);
      r = rst_n;
      cyc++;
      #1;
      if (!r) begin
        chk("reset_outputs", {bus.s_ready, bus.ff_valid, bus.ff_sop, bus.ff_eop, bus.ff_empty,
                              bus.ff_data, bus.m_tag_valid, bus.m_tag, bus.m_tag_eop,
                              bus.err_sop, bus.err_align}, '0);
      end else begin
        if (bus.ff_valid) begin
          if (ffq.size() == 0) chk("ff_unexpected_beat", 1, 0);
          else begin
            fe = ffq.pop_front();
            chk("ff_beat", {bus.ff_data, bus.ff_sop, bus.ff_eop, bus.ff_empty},
                           {fe.data, fe.sop, fe.eop, fe.empty});
            chk("ff_cycle", cyc, fe.cyc);
          end
        end else begin
          chk("ff_eop_idle", bus.ff_eop, 0);
        end
        if (bus.m_tag_valid) begin
          if (tagq.size() == 0) chk("tag_unexpected", 1, 0);
          else begin
            te = tagq.pop_front();
            chk("m_tag", {bus.m_tag, bus.m_tag_eop}, {TW'(te.port), te.eop});
            chk("tag_cycle", cyc, te.cyc);
          end
        end
        chk("err_sop", bus.err_sop, err_sop_exp);
        if (align_chk) chk("err_align", bus.err_align, 0);
        chk("ready_onehot0", $onehot0(bus.s_ready), 1);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = '0; bus.s_sop = '0; bus.s_eop = '0;
    bus.s_data = '0; bus.s_empty = '0; bus.ff_out_valid = 1'b0;
    do_reset(2);

    // Single 3-beat packet on port 2, empty=5.
    pq[2].push_back(mk(3, 0, 0, 0, EW'(5)));
    run_done(50, "t1");

    // All ports request single-beat packets at once after reset: order 0,1,2,3.
    do_reset(1);
    grant_log.delete();
    for (int i = 0; i < NP; i++) pq[i].push_back(mk(1, 0, 0, 0, EW'(i + 1)));
    run_done(60, "t2");
    chk("t2_grant_count", grant_log.size(), NP);
    for (int i = 0; i < grant_log.size(); i++) chk("t2_grant_order", grant_log[i], i);

    // Port 1 packet with a 2-cycle valid gap while port 0 waits.
    grant_log.delete();
    pq[1].push_back(mk(4, 0, 2, 2, EW'(7)));
    run(1);
    pq[0].push_back(mk(2, 0, 0, 0, EW'(3)));
    run_done(60, "t3");
    chk("t3_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) chk("t3_grant_order", {grant_log[0], grant_log[1]}, {32'd1, 32'd0});

    // Missing sop on port 3's first beat: sticky err_sop, data still forwarded.
    pq[3].push_back(mk(2, 1, 0, 0, EW'(2)));
    run_done(60, "t4");
    chk("t4_err_sop_set", bus.err_sop, 1);
    pq[1].push_back(mk(2, 0, 0, 0, EW'(1)));
    run_done(60, "t4b");
    chk("t4_err_sop_sticky", bus.err_sop, 1);

    // Reset in the middle of a 5-beat packet on port 0, then port 1 is served cleanly.
    do_reset(1);
    pq[0].push_back(mk(5, 0, 0, 0, EW'(9)));
    for (int c = 0; c < 50 && !(act[0] && beat[0] >= 2); c++) run(1);
    chk("t5_midpacket_reached", act[0] && beat[0] >= 2, 1);
    do_reset(1);
    chk("t5_after_reset", {bus.s_ready, bus.ff_valid, bus.m_tag_valid, bus.err_sop, bus.err_align}, 0);
    grant_log.delete();
    pq[1].push_back(mk(3, 0, 0, 0, EW'(4)));
    run_done(60, "t5");
    chk("t5_grant_port1", grant_log.size() > 0 ? grant_log[0] : -1, 1);
    chk("t5_err_flags", {bus.err_sop, bus.err_align}, 0);

    // Filter latency of 4 must trip err_align.
    do_reset(1);
    align_chk = 1'b0;
    flt_lat = 4;
    chk("t6_align_clear", bus.err_align, 0);
    pq[2].push_back(mk(2, 0, 0, 0, EW'(6)));
    run_done(60, "t6");
    run(3);
    chk("t6_err_align_set", bus.err_align, 1);
    flt_lat = LAT;
    do_reset(1);
    align_chk = 1'b1;

    // Randomized traffic: 100 packets, random ports, lengths, gaps and empties.
    for (int n = 0; n < 100; n++) begin
      int p, l, ga, gl;
      p  = $urandom_range(0, NP - 1);
      l  = $urandom_range(1, 6);
      ga = 0; gl = 0;
      if (l > 1 && $urandom_range(0, 2) == 0) begin
        ga = $urandom_range(1, l - 1);
        gl = $urandom_range(1, 3);
      end
      pq[p].push_back(mk(l, 0, ga, gl, EW'($urandom)));
      if ($urandom_range(0, 1) == 1) run($urandom_range(0, 4));
    end
    run_done(5000, "t7");
    run(LAT + 2);
    chk("t7_err_align_final", bus.err_align, 0);
    chk("t7_err_sop_final", bus.err_sop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
